// File: rtl/disp_pkg.sv
// Shared definitions for the display colour-depth adapter: conversion modes
// and the ordered-dither threshold matrix.
package disp_pkg;

  typedef enum logic [1:0] {
    MODE_TRUNC  = 2'd0,
    MODE_ROUND  = 2'd1,
    MODE_DITHER = 2'd2
  } mode_t;

  // Standard 4x4 Bayer matrix, row-major, thresholds 0..15.
  localparam logic [3:0] BAYER [16] = '{
    4'd0,  4'd8,  4'd2,  4'd10,
    4'd12, 4'd4,  4'd14, 4'd6,
    4'd3,  4'd11, 4'd1,  4'd9,
    4'd15, 4'd7,  4'd13, 4'd5
  };

  function automatic logic [3:0] bayer_thresh(input logic [1:0] row, input logic [1:0] col);
    return BAYER[{row, col}];
  endfunction

endpackage

// File: rtl/colour_chan_adapt.sv
// Combinational depth conversion of one colour channel: pad/replicate when
// widening, truncate/round/dither with saturation when narrowing.
module colour_chan_adapt
  import disp_pkg::*;
#(
  parameter int BPC_IN  = 5,
  parameter int BPC_OUT = 8
) (
  input  logic [BPC_IN-1:0]  value,
  input  logic [3:0]         thresh,
  input  mode_t              mode,
  output logic [BPC_OUT-1:0] result
);

  if (BPC_OUT >= BPC_IN) begin : g_expand
    logic [BPC_OUT-1:0] padded;
    logic [BPC_OUT-1:0] replicated;
    logic               unused_thresh;

    assign unused_thresh = ^thresh;

    // NOTE: every signal written in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
      padded     = '0;
      replicated = '0;
      padded[BPC_OUT-1 -: BPC_IN] = value;
      for (int i = 0; i < BPC_OUT; i++) begin
        replicated[BPC_OUT-1-i] = value[BPC_IN-1-(i % BPC_IN)];
      end
      result = (mode == MODE_TRUNC) ? padded : replicated;
    end
  end else begin : g_reduce
    localparam int D    = BPC_IN - BPC_OUT;
    localparam int SH_L = (D > 4) ? D - 4 : 0;
    localparam int SH_R = (D > 4) ? 0 : 4 - D;

    logic [BPC_IN+15:0] scaled;
    logic [BPC_IN:0]    bias;
    logic [BPC_IN:0]    sum;
    logic               unused_bits;

    // Dither threshold scaled to D bits; upper bits stay zero.
    assign scaled      = ((BPC_IN+16)'(thresh) << SH_L) >> SH_R;
    assign unused_bits = ^{sum[D-1:0], scaled[BPC_IN+15:BPC_IN+1]};

    always_comb begin
      bias = '0;
      case (mode)
        MODE_TRUNC:  bias = '0;
        MODE_DITHER: bias = scaled[BPC_IN:0];
        default:     bias = (BPC_IN+1)'(1) << (D - 1);
      endcase
      sum    = {1'b0, value} + bias;
      result = sum[BPC_IN] ? '1 : sum[BPC_IN-1:D];
    end
  end

endmodule

// File: rtl/disp_colour_adapt.sv
// Colour depth adapter between the core's pixel stream and the TMDS encoder.
// Two-stage pipeline; pixel position and frame phase derived from de/vsync.
module disp_colour_adapt
  import disp_pkg::*;
#(
  parameter int BPC_IN  = 5,
  parameter int BPC_OUT = 8,
  parameter bit VS_POL  = 1'b1,
  parameter bit HS_POL  = 1'b1
) (
  input  logic               clk_pix,
  input  logic               rst_pix_n,
  input  logic [1:0]         mode,
  input  logic               in_hsync,
  input  logic               in_vsync,
  input  logic               in_de,
  input  logic [BPC_IN-1:0]  in_r,
  input  logic [BPC_IN-1:0]  in_g,
  input  logic [BPC_IN-1:0]  in_b,
  output logic               out_hsync,
  output logic               out_vsync,
  output logic               out_de,
  output logic [BPC_OUT-1:0] out_r,
  output logic [BPC_OUT-1:0] out_g,
  output logic [BPC_OUT-1:0] out_b,
  output logic [1:0]         frame_cnt
);

  logic       vs_prev, de_prev;
  logic [1:0] px, py, px_cur;
  mode_t      act_mode, mode_sel;
  logic       vs_edge;
  logic [3:0] thresh;

  logic              s1_hs, s1_vs, s1_de;
  logic [BPC_IN-1:0] s1_r, s1_g, s1_b;
  logic [3:0]        s1_thresh;
  mode_t             s1_mode;

  logic [BPC_OUT-1:0] conv_r, conv_g, conv_b;

  assign vs_edge = (in_vsync == VS_POL) && (vs_prev != VS_POL);
  assign px_cur  = (in_de && !de_prev) ? 2'd0 : px;
  assign thresh  = bayer_thresh(py + {1'b0, frame_cnt[1]}, px_cur + {1'b0, frame_cnt[0]});

  always_comb begin
    case (mode)
      2'd0:    mode_sel = MODE_TRUNC;
      2'd2:    mode_sel = MODE_DITHER;
      default: mode_sel = MODE_ROUND;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      vs_prev   <= ~VS_POL;
      de_prev   <= 1'b0;
      px        <= '0;
      py        <= '0;
      frame_cnt <= '0;
      act_mode  <= MODE_ROUND;
    end else begin
      vs_prev <= in_vsync;
      de_prev <= in_de;
      if (in_de) px <= px_cur + 2'd1;
      // A new frame latches the mode and restarts the line count.
      if (vs_edge) begin
        py        <= '0;
        frame_cnt <= frame_cnt + 2'd1;
        act_mode  <= mode_sel;
      end else if (de_prev && !in_de) begin
        py <= py + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      s1_hs     <= ~HS_POL;
      s1_vs     <= ~VS_POL;
      s1_de     <= 1'b0;
      s1_r      <= '0;
      s1_g      <= '0;
      s1_b      <= '0;
      s1_thresh <= '0;
      s1_mode   <= MODE_ROUND;
      out_hsync <= ~HS_POL;
      out_vsync <= ~VS_POL;
      out_de    <= 1'b0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
    end else begin
      s1_hs     <= in_hsync;
      s1_vs     <= in_vsync;
      s1_de     <= in_de;
      s1_r      <= in_r;
      s1_g      <= in_g;
      s1_b      <= in_b;
      s1_thresh <= thresh;
      s1_mode   <= act_mode;
      out_hsync <= s1_hs;
      out_vsync <= s1_vs;
      out_de    <= s1_de;
      out_r     <= s1_de ? conv_r : '0;
      out_g     <= s1_de ? conv_g : '0;
      out_b     <= s1_de ? conv_b : '0;
    end
  end

  colour_chan_adapt #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT)) u_chan_r (
    .value(s1_r), .thresh(s1_thresh), .mode(s1_mode), .result(conv_r)
  );
  colour_chan_adapt #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT)) u_chan_g (
    .value(s1_g), .thresh(s1_thresh), .mode(s1_mode), .result(conv_g)
  );
  colour_chan_adapt #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT)) u_chan_b (
    .value(s1_b), .thresh(s1_thresh), .mode(s1_mode), .result(conv_b)
  );

endmodule

// File: tb/tb_disp_colour_adapt.sv
// Bench for disp_colour_adapt: an expanding (5->8) and a reducing (8->5)
// instance share syncs and mode; a behavioural model scores every output.
module tb_disp_colour_adapt;

  localparam int XI = 5;
  localparam int XO = 8;
  localparam int RI = 8;
  localparam int RO = 5;

  logic clk_pix = 1'b0;
  logic rst_pix_n;
  logic [1:0] mode;
  logic in_hsync, in_vsync, in_de;

  logic [XI-1:0] x_in_r, x_in_g, x_in_b;
  logic [XO-1:0] x_out_r, x_out_g, x_out_b;
  logic x_out_hsync, x_out_vsync, x_out_de;
  logic [1:0] x_frame;

  logic [RI-1:0] r_in_r, r_in_g, r_in_b;
  logic [RO-1:0] r_out_r, r_out_g, r_out_b;
  logic r_out_hsync, r_out_vsync, r_out_de;
  logic [1:0] r_frame;

  always #5 clk_pix = ~clk_pix;

  disp_colour_adapt #(.BPC_IN(XI), .BPC_OUT(XO), .VS_POL(1'b1), .HS_POL(1'b1)) dut_exp (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .mode(mode),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
    .in_r(x_in_r), .in_g(x_in_g), .in_b(x_in_b),
    .out_hsync(x_out_hsync), .out_vsync(x_out_vsync), .out_de(x_out_de),
    .out_r(x_out_r), .out_g(x_out_g), .out_b(x_out_b), .frame_cnt(x_frame)
  );

  disp_colour_adapt #(.BPC_IN(RI), .BPC_OUT(RO), .VS_POL(1'b1), .HS_POL(1'b0)) dut_red (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .mode(mode),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
    .in_r(r_in_r), .in_g(r_in_g), .in_b(r_in_b),
    .out_hsync(r_out_hsync), .out_vsync(r_out_vsync), .out_de(r_out_de),
    .out_r(r_out_r), .out_g(r_out_g), .out_b(r_out_b), .frame_cnt(r_frame)
  );

  typedef struct {
    bit hs, vs, de;
    int xr, xg, xb;
    int rr, rg, rb;
    int tag;
  } exp_t;

  exp_t q[$];
  int n_checks, n_fail;
  int cap_x [32];
  int cap_r [32];
  int f0 [16];
  int f1 [16];
  int bayer_tbl [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};

  int m_frame, m_mode, m_px, m_py;
  bit m_prev_de, m_prev_vs;

  function automatic int ref_conv(int v, int bin, int bout, int md, int t);
    int maxv;
    int acc;
    int d;
    int bias;
    maxv = (1 << bout) - 1;
    if (bout >= bin) begin
      if (md == 0) return v << (bout - bin);
      acc = 0;
      for (int p = bout - bin; p > -bin; p -= bin)
        acc |= (p >= 0) ? (v << p) : (v >> (-p));
      return acc;
    end
    d = bin - bout;
    if (md == 0) bias = 0;
    else if (md == 1) bias = 1 << (d - 1);
    else bias = (d <= 4) ? (t >> (4 - d)) : (t << (d - 4));
    acc = (v + bias) >> d;
    return (acc > maxv) ? maxv : acc;
  endfunction

  task automatic reset_model();
    m_frame = 0; m_mode = 1; m_px = 0; m_py = 0;
    m_prev_de = 0; m_prev_vs = 0;
    q.delete();
  endtask

  task automatic drive_cycle(input bit hs, input bit vs, input bit de,
                             input int r5, input int g5, input int b5,
                             input int r8, input int g8, input int b8, input int tag);
    exp_t e;
    int x, row, col, t;
    bit vedge;
    in_hsync = hs; in_vsync = vs; in_de = de;
    x_in_r = XI'(r5); x_in_g = XI'(g5); x_in_b = XI'(b5);
    r_in_r = RI'(r8); r_in_g = RI'(g8); r_in_b = RI'(b8);
    vedge = vs && !m_prev_vs;
    x = (de && !m_prev_de) ? 0 : m_px;
    row = (m_py + (m_frame >> 1)) % 4;
    col = (x + (m_frame & 1)) % 4;
    t = bayer_tbl[row * 4 + col];
    e.hs = hs; e.vs = vs; e.de = de; e.tag = tag;
    e.xr = de ? ref_conv(r5, XI, XO, m_mode, t) : 0;
    e.xg = de ? ref_conv(g5, XI, XO, m_mode, t) : 0;
    e.xb = de ? ref_conv(b5, XI, XO, m_mode, t) : 0;
    e.rr = de ? ref_conv(r8, RI, RO, m_mode, t) : 0;
    e.rg = de ? ref_conv(g8, RI, RO, m_mode, t) : 0;
    e.rb = de ? ref_conv(b8, RI, RO, m_mode, t) : 0;
    if (de) m_px = (x + 1) % 4;
    if (vedge) begin
      m_py = 0;
      m_frame = (m_frame + 1) % 4;
      m_mode = (mode == 2'd3) ? 1 : int'(mode);
    end else if (m_prev_de && !de) begin
      m_py = (m_py + 1) % 4;
    end
    m_prev_de = de; m_prev_vs = vs;
    q.push_back(e);
    @(posedge clk_pix); #1;
    n_checks++;
    if (x_frame !== 2'(m_frame) || r_frame !== 2'(m_frame)) begin
      n_fail++;
      $display("FAIL frame_cnt: got %0d/%0d expected %0d", x_frame, r_frame, m_frame);
    end
    if (q.size() == 2) begin
      e = q.pop_front();
      if (e.tag >= 0) begin
        cap_x[e.tag] = int'(x_out_r);
        cap_r[e.tag] = int'(r_out_r);
      end
      n_checks++;
      if ({x_out_hsync, x_out_vsync, x_out_de} !== {e.hs, e.vs, e.de} ||
          {r_out_hsync, r_out_vsync, r_out_de} !== {e.hs, e.vs, e.de}) begin
        n_fail++;
        $display("FAIL sync_delay: got %b%b%b/%b%b%b expected %b%b%b", x_out_hsync, x_out_vsync,
                 x_out_de, r_out_hsync, r_out_vsync, r_out_de, e.hs, e.vs, e.de);
      end
      n_checks++;
      if (x_out_r !== XO'(e.xr) || x_out_g !== XO'(e.xg) || x_out_b !== XO'(e.xb)) begin
        n_fail++;
        $display("FAIL expand_rgb: got %h %h %h expected %h %h %h", x_out_r, x_out_g, x_out_b,
                 e.xr, e.xg, e.xb);
      end
      n_checks++;
      if (r_out_r !== RO'(e.rr) || r_out_g !== RO'(e.rg) || r_out_b !== RO'(e.rb)) begin
        n_fail++;
        $display("FAIL reduce_rgb: got %h %h %h expected %h %h %h", r_out_r, r_out_g, r_out_b,
                 e.rr, e.rg, e.rb);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
  endtask

  task automatic vsync_pulse(input logic [1:0] md);
    mode = md;
    drive_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, -1);
    drive_cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, -1);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
  endtask

  task automatic pixel(input int v5, input int v8, input int tag);
    drive_cycle(1'($urandom_range(0, 1)), 0, 1, v5, $urandom_range(0, 31), $urandom_range(0, 31),
                v8, $urandom_range(0, 255), $urandom_range(0, 255), tag);
  endtask

  task automatic drive_frame(input int v8);
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++)
        drive_cycle(0, 0, 1, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                    v8, v8, v8, y * 4 + x);
      drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, -1);
      drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    end
    idle(3);
  endtask

  task automatic test_reset();
    rst_pix_n = 1'b0;
    repeat (3) @(posedge clk_pix);
    #1;
    n_checks++;
    if (x_out_r !== '0 || x_out_g !== '0 || x_out_b !== '0 || x_out_de !== 1'b0 ||
        r_out_r !== '0 || r_out_g !== '0 || r_out_b !== '0 || r_out_de !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_colour: got %h %h %h de%b / %h %h %h de%b expected all 0",
               x_out_r, x_out_g, x_out_b, x_out_de, r_out_r, r_out_g, r_out_b, r_out_de);
    end
    n_checks++;
    if ({x_out_hsync, x_out_vsync, r_out_hsync, r_out_vsync} !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_syncs: got %b%b%b%b expected 0010", x_out_hsync, x_out_vsync,
               r_out_hsync, r_out_vsync);
    end
    n_checks++;
    if (x_frame !== 2'd0 || r_frame !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_frame: got %0d/%0d expected 0", x_frame, r_frame);
    end
    @(negedge clk_pix);
    rst_pix_n = 1'b1;
    reset_model();
  endtask

  task automatic test_expand_round();
    pixel('h1F, $urandom_range(0, 255), 0);
    pixel('h10, $urandom_range(0, 255), 1);
    pixel('h00, $urandom_range(0, 255), 2);
    idle(3);
    n_checks++;
    if (cap_x[0] !== 'hFF || cap_x[1] !== 'h84 || cap_x[2] !== 'h00) begin
      n_fail++;
      $display("FAIL expand_round: got %h %h %h expected ff 84 00", cap_x[0], cap_x[1], cap_x[2]);
    end
  endtask

  task automatic test_expand_trunc();
    vsync_pulse(2'd0);
    pixel('h10, $urandom_range(0, 255), 0);
    pixel('h1F, $urandom_range(0, 255), 1);
    idle(3);
    n_checks++;
    if (cap_x[0] !== 'h80 || cap_x[1] !== 'hF8) begin
      n_fail++;
      $display("FAIL expand_trunc: got %h %h expected 80 f8", cap_x[0], cap_x[1]);
    end
  endtask

  task automatic test_reduce_round();
    vsync_pulse(2'd1);
    pixel($urandom_range(0, 31), 'h83, 0);
    pixel($urandom_range(0, 31), 'h84, 1);
    pixel($urandom_range(0, 31), 'hFE, 2);
    idle(3);
    n_checks++;
    if (cap_r[0] !== 'h10 || cap_r[1] !== 'h11 || cap_r[2] !== 'h1F) begin
      n_fail++;
      $display("FAIL reduce_round: got %h %h %h expected 10 11 1f", cap_r[0], cap_r[1], cap_r[2]);
    end
  endtask

  task automatic test_dither();
    int n11, n10;
    bit shifted;
    vsync_pulse(2'd2);
    for (int k = 0; k < 4 && m_frame != 0; k++) vsync_pulse(2'd2);
    drive_frame('h84);
    n11 = 0; n10 = 0;
    for (int i = 0; i < 16; i++) begin
      f0[i] = cap_r[i];
      if (cap_r[i] == 'h11) n11++;
      if (cap_r[i] == 'h10) n10++;
    end
    n_checks++;
    if (n11 != 8 || n10 != 8) begin
      n_fail++;
      $display("FAIL dither_count: got %0d x11 %0d x10 expected 8 and 8", n11, n10);
    end
    n_checks++;
    if (f0[0] !== 'h10) begin
      n_fail++;
      $display("FAIL dither_origin: got %h expected 10", f0[0]);
    end
    vsync_pulse(2'd2);
    drive_frame('h84);
    shifted = 1;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) begin
        f1[y * 4 + x] = cap_r[y * 4 + x];
        if (cap_r[y * 4 + x] != f0[y * 4 + (x + 1) % 4]) shifted = 0;
      end
    n_checks++;
    if (!shifted) begin
      n_fail++;
      $display("FAIL dither_shift: row0 got %h %h %h %h frame0 row0 %h %h %h %h",
               f1[0], f1[1], f1[2], f1[3], f0[0], f0[1], f0[2], f0[3]);
    end
  endtask

  task automatic test_mode_switch();
    vsync_pulse(2'd1);
    pixel('h10, $urandom_range(0, 255), 0);
    pixel($urandom_range(0, 31), $urandom_range(0, 255), 1);
    mode = 2'd0;
    pixel('h10, $urandom_range(0, 255), 2);
    drive_cycle(0, 0, 0, 'h1F, 'h1F, 'h1F, 'hFF, 'hFF, 'hFF, 3);
    idle(3);
    n_checks++;
    if (cap_x[0] !== 'h84 || cap_x[2] !== 'h84) begin
      n_fail++;
      $display("FAIL mode_hold: got %h %h expected 84 84", cap_x[0], cap_x[2]);
    end
    n_checks++;
    if (cap_x[3] !== 0 || cap_r[3] !== 0) begin
      n_fail++;
      $display("FAIL blanking: got %h/%h expected 0", cap_x[3], cap_r[3]);
    end
    vsync_pulse(2'd0);
    pixel('h10, $urandom_range(0, 255), 4);
    idle(3);
    n_checks++;
    if (cap_x[4] !== 'h80) begin
      n_fail++;
      $display("FAIL mode_switch: got %h expected 80", cap_x[4]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 59) == 0)
        vsync_pulse(2'($urandom_range(0, 3)));
      else
        drive_cycle(1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 3) != 0),
                    $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), -1);
    end
    idle(3);
  endtask

  task automatic test_reset_mid();
    bit same;
    vsync_pulse(2'd2);
    for (int i = 0; i < 3; i++) pixel($urandom_range(0, 31), $urandom_range(0, 255), -1);
    #2;
    rst_pix_n = 1'b0;
    #1;
    n_checks++;
    if (x_out_r !== '0 || x_out_de !== 1'b0 || r_out_r !== '0 || r_out_de !== 1'b0 ||
        {x_out_hsync, x_out_vsync, r_out_hsync, r_out_vsync} !== 4'b0010 ||
        x_frame !== 2'd0 || r_frame !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got r%h de%b syncs %b%b%b%b frame %0d", x_out_r, x_out_de,
               x_out_hsync, x_out_vsync, r_out_hsync, r_out_vsync, x_frame);
    end
    in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0;
    repeat (2) @(posedge clk_pix);
    @(negedge clk_pix);
    rst_pix_n = 1'b1;
    reset_model();
    vsync_pulse(2'd2);
    drive_frame('h84);
    same = 1;
    for (int i = 0; i < 16; i++) if (cap_r[i] != f1[i]) same = 0;
    n_checks++;
    if (!same) begin
      n_fail++;
      $display("FAIL reset_phase: row0 got %h %h %h %h expected %h %h %h %h",
               cap_r[0], cap_r[1], cap_r[2], cap_r[3], f1[0], f1[1], f1[2], f1[3]);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    mode = 2'd1;
    in_hsync = 1'b0; in_vsync = 1'b0; in_de = 1'b0;
    x_in_r = '0; x_in_g = '0; x_in_b = '0;
    r_in_r = '0; r_in_g = '0; r_in_b = '0;
    reset_model();
    test_reset();
    test_expand_round();
    test_expand_trunc();
    test_reduce_round();
    test_dither();
    test_mode_switch();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
